// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: game FSM, round countdown, and paced random LED requests to the hit-detector.
// Latency: a request appears 1 cycle after its slot fires when the candidate LED is free, plus 1 cycle per busy LED probed.
// Backpressure: led_busy stalls selection; after NUM_LEDS busy probes the slot is dropped. Optional macro HIGH_SCORE_EN adds the high-score register.
module mole_scheduler #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int NUM_LEDS        = 18,
    parameter int GAME_TIME_SEC   = 30,
    parameter int START_PERIOD_MS = 1000,
    parameter int MIN_PERIOD_MS   = 250,
    parameter int STEP_MS         = 50,
    parameter int RAMP_EVERY      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_LEDS-1:0] led_busy,
    input  logic [11:0]         score,
    output logic [4:0]          led_index,
    output logic                led_request,
    output logic                score_clr,
    output logic                game_active,
    output logic                game_over,
    output logic [7:0]          time_left,
    output logic [11:0]         high_score
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TICK_W   = $clog2(TICK_DIV + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [4:0]  NL        = 5'(NUM_LEDS);
    localparam logic [4:0]  NL_LAST   = 5'(NUM_LEDS - 1);
    localparam logic [15:0] P_START   = 16'(START_PERIOD_MS);
    localparam logic [15:0] P_MIN     = 16'(MIN_PERIOD_MS);
    localparam logic [15:0] P_STEP    = 16'(STEP_MS);
    localparam logic [7:0]  RAMP_LAST = 8'(RAMP_EVERY - 1);
    localparam logic [7:0]  T_GAME    = 8'(GAME_TIME_SEC);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t              state;
    logic [15:0]         lfsr;
    logic [TICK_W-1:0]   tick_cnt;
    logic [9:0]          sec_ms;
    logic [15:0]         slot_cnt;
    logic [15:0]         period;
    logic [7:0]          issued;
    logic                sel_active;
    logic [4:0]          probe_idx;
    logic [4:0]          probe_cnt;

    logic                tick;
    logic                sec_wrap;
    logic                ending;
    logic                slot_fire;
    logic [4:0]          cand;
    logic                issue_vld;
    logic [4:0]          issue_idx;

    function automatic logic [4:0] wrap_inc(input logic [4:0] idx);
        return (idx == NL_LAST) ? 5'd0 : idx + 5'd1;
    endfunction

    // 1 ms tick only advances while playing; the last second rolling over ends the round.
    assign tick      = (state == PLAY) && (tick_cnt == TICK_LAST);
    assign sec_wrap  = tick && (sec_ms == 10'd999);
    assign ending    = (time_left == 8'd0) || (sec_wrap && (time_left == 8'd1));
    assign slot_fire = tick && ((slot_cnt + 16'd1) == period);
    assign cand      = (lfsr[4:0] >= NL) ? (lfsr[4:0] - NL) : lfsr[4:0];

    // Free-running Galois LFSR (taps 16,14,13,11); start timing decorrelates each game's sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Decide whether this cycle hands an LED to the hit-detector: fresh candidate on a slot, else the current probe.
    always_comb begin
        issue_vld = 1'b0;
        issue_idx = cand;
        if ((state == PLAY) && !ending) begin
            if (slot_fire) begin
                issue_vld = !led_busy[cand];
            end else if (sel_active) begin
                issue_vld = !led_busy[probe_idx];
                issue_idx = probe_idx;
            end
        end
    end

    // Game FSM with round/slot timers, probing, difficulty ramp and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            game_active <= 1'b0;
            game_over   <= 1'b0;
            score_clr   <= 1'b0;
            led_request <= 1'b0;
            led_index   <= '0;
            time_left   <= '0;
            period      <= P_START;
            tick_cnt    <= '0;
            sec_ms      <= '0;
            slot_cnt    <= '0;
            issued      <= '0;
            sel_active  <= 1'b0;
            probe_idx   <= '0;
            probe_cnt   <= '0;
        end else begin
            led_request <= 1'b0;
            score_clr   <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state       <= PLAY;
                        game_active <= 1'b1;
                        game_over   <= 1'b0;
                        score_clr   <= 1'b1;
                        time_left   <= T_GAME;
                        period      <= P_START;
                        tick_cnt    <= '0;
                        sec_ms      <= '0;
                        slot_cnt    <= '0;
                        issued      <= '0;
                        sel_active  <= 1'b0;
                    end
                end
                PLAY: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) begin
                        sec_ms   <= sec_wrap ? '0 : sec_ms + 10'd1;
                        slot_cnt <= slot_fire ? '0 : slot_cnt + 16'd1;
                    end
                    if (sec_wrap && (time_left != 8'd0)) begin
                        time_left <= time_left - 8'd1;
                    end

                    // A ramp step shortens the interval from the next slot onward.
                    if (issue_vld) begin
                        led_request <= 1'b1;
                        led_index   <= issue_idx;
                        if (issued == RAMP_LAST) begin
                            issued <= '0;
                            period <= (period >= (P_MIN + P_STEP)) ? (period - P_STEP) : P_MIN;
                        end else begin
                            issued <= issued + 8'd1;
                        end
                    end

                    // A new slot always restarts selection; running out of time aborts it.
                    if (time_left == 8'd0) begin
                        state       <= OVER;
                        game_active <= 1'b0;
                        game_over   <= 1'b1;
                        sel_active  <= 1'b0;
                    end else if (ending || issue_vld) begin
                        sel_active <= 1'b0;
                    end else if (slot_fire) begin
                        sel_active <= 1'b1;
                        probe_idx  <= wrap_inc(cand);
                        probe_cnt  <= 5'd1;
                    end else if (sel_active) begin
                        if (probe_cnt == NL_LAST) begin
                            sel_active <= 1'b0;
                        end else begin
                            probe_idx <= wrap_inc(probe_idx);
                            probe_cnt <= probe_cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    logic over_q;

    // On the first OVER cycle compare the final score; only a strictly better score replaces the record.
    always_ff @(posedge clk) begin
        if (rst) begin
            over_q     <= 1'b0;
            high_score <= '0;
        end else begin
            over_q <= game_over;
            if (game_over && !over_q && (score > high_score)) begin
                high_score <= score;
            end
        end
    end
`else
    logic unused_score;

    assign high_score   = '0;
    assign unused_score = ^score;
`endif

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Game-level controller that sequences the LED/switch hit-detector for the whack-a-mole game.
- Runs the game state machine and the round countdown.
- Generates pseudo-random LED requests at a period that shortens as the game progresses.
- Clears the hit-detector's score at game start and tracks the high score.
- Sits between the top-level start button/display logic and the LED/switch block. It drives that block's `led_index`/`led_request` and reads its `leds`/`score`.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; the 1 ms tick divisor is CLK_HZ/1000.
- NUM_LEDS, 18, number of LED/switch pairs.
- GAME_TIME_SEC, 30, round length in seconds.
- START_PERIOD_MS, 1000, initial interval between request slots.
- MIN_PERIOD_MS, 250, floor for the interval.
- STEP_MS, 50, interval decrement per ramp step.
- RAMP_EVERY, 8, issued requests per ramp step.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle start pulse (debounced upstream)
- led_busy  in  18  current LED states from the hit-detector
- score  in  12  current score from the hit-detector
- led_index  out  5  LED to light; valid only while led_request=1
- led_request  out  1  single-cycle request pulse
- score_clr  out  1  single-cycle pulse; top level ORs it into the hit-detector reset
- game_active  out  1  high in PLAY
- game_over  out  1  high in OVER
- time_left  out  8  seconds remaining
- high_score  out  12  best final score since reset

Behaviour:
- Reset: state=IDLE; all outputs 0; LFSR=16'hACE1; period=START_PERIOD_MS; all counters 0.
- LFSR: 16-bit Galois, taps 16,14,13,11. Free-runs every cycle in all states, so start timing randomises the sequence.
- ms tick: 1-cycle pulse every CLK_HZ/1000 clocks. The tick counter runs only in PLAY and is cleared on PLAY entry.
- States:
  - IDLE: start -> PLAY.
  - PLAY: time_left reaches 0 -> OVER. start is ignored.
  - OVER: start -> PLAY.
- PLAY entry (cycle after start is sampled):
  - score_clr=1 for exactly that cycle.
  - time_left=GAME_TIME_SEC; period=START_PERIOD_MS; slot ms counter=0; issued count=0.
- Countdown: every 1000 ticks, time_left decrements. When it reaches 0, the next cycle enters OVER.
- Slot timing: the slot ms counter increments on each tick. When it equals period, the counter clears and a selection starts. The interval is measured in ticks between selection starts and is independent of probe cycles.
- Selection:
  - Candidate = lfsr[4:0]; if the value is >= NUM_LEDS, subtract NUM_LEDS.
  - If led_busy[candidate]=0: led_request=1 with led_index=candidate on the next cycle, and the issued count increments.
  - Otherwise probe candidate+1 (mod NUM_LEDS), one per cycle, up to NUM_LEDS probes. If all are busy, the slot is dropped: no request and no count increment.
- Ramp: when the issued count reaches RAMP_EVERY, the count resets to 0 and period = max(period-STEP_MS, MIN_PERIOD_MS), saturating at the floor. The new period applies from the next slot.
- If a selection is in progress when time_left reaches 0, it is aborted and no request is issued.
- led_request is never asserted outside PLAY.
- OVER entry:
  - game_over=1; game_active=0.
  - One cycle later, the high-score update below runs.
  - time_left holds 0.
- Reset mid-game returns to IDLE immediately with the reset values above. high_score is also cleared.
- score is sampled as unsigned 12-bit. There is no wrap handling beyond 12 bits.

Optional Feature:
- HIGH_SCORE_EN defined: high_score register is implemented. One cycle after OVER entry, if score > high_score, high_score is updated to score; equal or lower scores leave it unchanged.
- HIGH_SCORE_EN undefined: high_score is tied to 0, with no register and no comparator.

Test Plan:
- Assert rst for 2 cycles, then release -> all outputs 0, state IDLE; led_request stays 0 for 1000 cycles with no start.
- Bench parameters CLK_HZ=1000, START_PERIOD_MS=4, led_busy=0; pulse start -> score_clr high on the following cycle only; first led_request arrives 4 ticks (plus selection latency) after PLAY entry; led_index < 18.
- led_busy=18'h3FFFF during a slot -> no led_request; probing ends after 18 cycles; issued count unchanged. Set only bit 17 clear -> request with led_index=17.
- RAMP_EVERY=2, STEP_MS=1, START_PERIOD_MS=4, MIN_PERIOD_MS=2 -> intervals between request slots are 4,4,3,3,2,2,2.
- GAME_TIME_SEC=2 -> game_over after 2000 ticks. With score=7, high_score becomes 7 (HIGH_SCORE_EN). In a second game, score=5 -> high_score stays 7. Without the macro, high_score stays 0.
- Assert rst mid-PLAY during a probe -> next cycle IDLE; no led_request; time_left=0; high_score=0.
